sram_addr_gen: RTL
==================

SRAM_ADDR_GEN -- requirements
Module: sram_addr_gen

Interface
REQ-001 The block SHALL use a single clock domain; reset is synchronous and active-high.
REQ-002 avr_clk  input  1  system clock; all state updates on rising edge.
REQ-003 avr_reset  input  1  synchronous active-high reset.
REQ-004 avr_si  input  1  serial address data bit from the command stage.
REQ-005 avr_sreg_en_n  input  1  active-low shift-register enable; low selects serial load.
REQ-006 avr_counter_n  input  1  active-low step strobe; each falling edge is one step.
REQ-007 avr_snes_mode  input  1  high hands the SRAM bus to the SNES.
REQ-008 snes_addr  input  24  SNES address, passed through in SNES mode.
REQ-009 sram_addr  output  24  SRAM address bus.
REQ-010 addr_valid  output  1  high while a complete 24-bit address is held (state READY).
REQ-011 addr_wrap  output  1  one-cycle pulse on increment wrap from 0xFFFFFF to 0x000000.

Function
REQ-012 avr_si, avr_sreg_en_n, avr_counter_n and avr_snes_mode SHALL each pass through a 2-flop synchronizer; all decisions SHALL use the synchronized values.
REQ-013 A step pulse SHALL assert for exactly one cycle when synced counter_n goes 1->0; step takes effect 3 avr_clk edges after the input falls.
REQ-014 FSM states: IDLE, SHIFT, READY.
REQ-015 Any state, synced sreg_en_n low, current state not SHIFT -> SHIFT; bit_cnt cleared to 0, addr register kept.
REQ-016 SHIFT, step: addr <= {addr[22:0], si_sync}; bit_cnt increments and saturates at 24.
REQ-017 SHIFT, synced sreg_en_n high: bit_cnt == 24 -> READY; otherwise -> IDLE, addr kept.
REQ-018 READY, step: addr <= addr + 1, modulo 2^24; on 0xFFFFFF -> 0x000000, addr_wrap pulses in the same cycle as the update.
REQ-019 IDLE: steps ignored; addr held.
REQ-020 A step arriving in the cycle synced sreg_en_n first reads low SHALL be a shift, with bit_cnt counting from 0 (result bit_cnt = 1).
REQ-021 Synced snes_mode high: sram_addr = snes_addr combinationally; steps ignored; FSM, addr and bit_cnt frozen; addr_valid forced low.
REQ-022 Synced snes_mode low: sram_addr = addr register.
REQ-023 More than 24 shifts SHALL keep shifting (last 24 bits retained); bit_cnt stays 24.

Reset
REQ-024 On avr_reset: state IDLE, addr 0x000000, bit_cnt 0, addr_valid 0, addr_wrap 0.
REQ-025 Synchronizer flops reset to inactive levels: counter_n 1, sreg_en_n 1, si 0, snes_mode 0; no step pulse in the first cycle after reset.
REQ-026 Reset asserted mid-SHIFT or mid-increment SHALL override all other updates in that cycle.

Configuration
REQ-027 Macro SREG_READBACK_EN: when defined, adds output avr_so (1 bit) = addr[23], so the AVR can read the loaded address serially (updates with each shift); when undefined the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-028 Shared package qd2_addr_pkg SHALL hold ADDR_W = 24, the FSM state enum and the synchronizer reset constants.
REQ-029 One sub-module, sync_edge: 2-flop synchronizer plus falling-edge pulse; instantiated for counter_n (edge output used) and for the other three inputs (level only).

Verification
REQ-030 Reset, then sreg_en_n low, 24 steps shifting 0x12_3456 MSB first, then sreg_en_n high -> addr_valid = 1, sram_addr = 0x123456.
REQ-031 READY at 0xFFFFFE, two steps -> sram_addr 0xFFFFFF, then 0x000000 with addr_wrap high for exactly 1 cycle.
REQ-032 sreg_en_n low, 10 steps, sreg_en_n high -> state IDLE, addr_valid = 0; further steps leave sram_addr unchanged.
REQ-033 READY at 0x000100, snes_mode high, snes_addr = 0xABCDEF, 3 steps -> sram_addr = 0xABCDEF, addr_valid = 0; snes_mode low -> sram_addr = 0x000100, addr_valid = 1.
REQ-034 avr_reset during 12th shift -> next cycle addr 0x000000, state IDLE, bit_cnt 0.
REQ-035 SREG_READBACK_EN defined, load 0x800001 -> avr_so = 1 after load, avr_so = 0 after one extra shift of si = 0.

Source files
------------

// File: rtl/qd2_addr_pkg.sv
// Shared constants, FSM state type and synchronizer reset levels for the
// SRAM address generator.
package qd2_addr_pkg;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned CNT_W  = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_READY = 2'd2
   } state_e;

   // Inactive levels loaded into the synchronizers on reset
   localparam logic SYNC_RST_COUNTER_N = 1'b1;
   localparam logic SYNC_RST_SREG_EN_N = 1'b1;
   localparam logic SYNC_RST_SI        = 1'b0;
   localparam logic SYNC_RST_SNES_MODE = 1'b0;

endpackage

// File: rtl/sram_addr_gen_if.sv
// AVR/SNES-facing signal bundle of sram_addr_gen.
// Optional SREG_READBACK_EN adds the serial readback line avr_so.
interface sram_addr_gen_if;
   import qd2_addr_pkg::*;

   logic              avr_si;
   logic              avr_sreg_en_n;
   logic              avr_counter_n;
   logic              avr_snes_mode;
   logic [ADDR_W-1:0] snes_addr;
   logic [ADDR_W-1:0] sram_addr;
   logic              addr_valid;
   logic              addr_wrap;
`ifdef SREG_READBACK_EN
   logic              avr_so;
`endif

   modport master (
      output avr_si, avr_sreg_en_n, avr_counter_n, avr_snes_mode, snes_addr,
`ifdef SREG_READBACK_EN
      input  avr_so,
`endif
      input  sram_addr, addr_valid, addr_wrap
   );

   modport slave (
      input  avr_si, avr_sreg_en_n, avr_counter_n, avr_snes_mode, snes_addr,
`ifdef SREG_READBACK_EN
      output avr_so,
`endif
      output sram_addr, addr_valid, addr_wrap
   );

endinterface

// File: rtl/sram_addr_gen_sync_edge.sv
// 2-flop synchronizer with a one-cycle pulse on a synchronized 1->0 transition.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic fall_o
);

   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {2{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[0], d_i};
         prev_q <= sync_q[1];
      end
   end

   assign q_o    = sync_q[1];
   assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/sram_addr_gen.sv
// SRAM address generator: serial address load from the AVR, step-increment,
// SNES bus pass-through. Define SREG_READBACK_EN to add serial readback avr_so.
module sram_addr_gen
   import qd2_addr_pkg::*;
(
   input  logic           avr_clk,
   input  logic           avr_reset,
   sram_addr_gen_if.slave bus
);

   logic si_s, sreg_en_n_s, counter_n_s, snes_s, step;
   logic [2:0] unused_fall;

   sync_edge #(.RST_VAL(SYNC_RST_COUNTER_N)) u_sync_cnt (
      .clk_i(avr_clk), .rst_i(avr_reset), .d_i(bus.avr_counter_n),
      .q_o(counter_n_s), .fall_o(step)
   );
   sync_edge #(.RST_VAL(SYNC_RST_SREG_EN_N)) u_sync_sreg (
      .clk_i(avr_clk), .rst_i(avr_reset), .d_i(bus.avr_sreg_en_n),
      .q_o(sreg_en_n_s), .fall_o(unused_fall[0])
   );
   sync_edge #(.RST_VAL(SYNC_RST_SI)) u_sync_si (
      .clk_i(avr_clk), .rst_i(avr_reset), .d_i(bus.avr_si),
      .q_o(si_s), .fall_o(unused_fall[1])
   );
   sync_edge #(.RST_VAL(SYNC_RST_SNES_MODE)) u_sync_snes (
      .clk_i(avr_clk), .rst_i(avr_reset), .d_i(bus.avr_snes_mode),
      .q_o(snes_s), .fall_o(unused_fall[2])
   );

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wrap_q, wrap_d;
   logic [ADDR_W-1:0] shift_addr;

   assign shift_addr = {addr_q[ADDR_W-2:0], si_s};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (!snes_s) begin
         if (!sreg_en_n_s && state_q != ST_SHIFT) begin
            // A step coinciding with shift entry is the first shifted bit
            state_d = ST_SHIFT;
            cnt_d   = '0;
            if (step) begin
               addr_d = shift_addr;
               cnt_d  = CNT_W'(1);
            end
         end else begin
            case (state_q)
               ST_SHIFT: begin
                  if (sreg_en_n_s) begin
                     state_d = (cnt_q == CNT_FULL) ? ST_READY : ST_IDLE;
                  end else if (step) begin
                     addr_d = shift_addr;
                     if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_READY: begin
                  if (step) begin
                     addr_d = addr_q + ADDR_W'(1);
                     wrap_d = (addr_q == '1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge avr_clk) begin
      if (avr_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.sram_addr  = snes_s ? bus.snes_addr : addr_q;
   assign bus.addr_valid = (state_q == ST_READY) && !snes_s;
   assign bus.addr_wrap  = wrap_q;

`ifdef SREG_READBACK_EN
   assign bus.avr_so = addr_q[ADDR_W-1];
`endif

endmodule
